pmt_pulse_conditioner: RTL



---
 rtl/pmt_pulse_conditioner.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pmt_pulse_conditioner.sv
// PMT discriminator front end: synchronise, reject short glitches, enforce a
// non-paralyzable dead time, emit one strobe per accepted photon, keep stats.
module pmt_pulse_conditioner #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_WIDTH   = 3,
  parameter int unsigned DEAD_TIME   = 8,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clock_50_mhz,
  input  logic                 reset_n,
  input  logic                 PMT_in,
  input  logic                 enable,
  input  logic                 clear_stats,
  output logic                 pulse_strobe,
  output logic                 pmt_level,
  output logic [CNT_WIDTH-1:0] accepted_count,
  output logic [CNT_WIDTH-1:0] glitch_count,
  output logic [CNT_WIDTH-1:0] deadtime_count,
  output logic                 overflow
);

  localparam int unsigned WW = $clog2(MIN_WIDTH + 1);
  localparam int unsigned DW = (DEAD_TIME > 0) ? $clog2(DEAD_TIME + 1) : 1;
  localparam logic [WW-1:0] MinLast = WW'(MIN_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StQualify, StHigh, StDead} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_valid_q;
  logic                   s;
  logic                   s_prev_q;
  logic                   rise;
  state_e                 state_q;
  logic [WW-1:0]          width_q;
  logic [DW-1:0]          dead_q;
  logic                   inc_acc;
  logic                   inc_glitch;
  logic                   inc_dead;

  assign s         = sync_q[SYNC_STAGES-1];
  assign pmt_level = s;
  assign rise      = s & ~s_prev_q;

  // s_prev holds 1 until the synchroniser has filled, so a level already high
  // out of reset is not mistaken for a rising edge.
  always_ff @(posedge clock_50_mhz or negedge reset_n) begin
    if (!reset_n) begin
      sync_q       <= '0;
      sync_valid_q <= '0;
      s_prev_q     <= 1'b1;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], PMT_in};
      sync_valid_q <= {sync_valid_q[SYNC_STAGES-2:0], 1'b1};
      s_prev_q     <= sync_valid_q[SYNC_STAGES-1] ? s : 1'b1;
    end
  end

  always_comb begin
    inc_acc    = 1'b0;
    inc_glitch = 1'b0;
    inc_dead   = 1'b0;
    if (enable) begin
      unique case (state_q)
        StIdle:    inc_acc = rise && (MIN_WIDTH == 1);
        StQualify: begin
          if (s) inc_acc = (width_q == MinLast);
          else   inc_glitch = 1'b1;
        end
        StDead:    inc_dead = rise;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clock_50_mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      width_q      <= '0;
      dead_q       <= '0;
      pulse_strobe <= 1'b0;
    end else begin
      pulse_strobe <= inc_acc;
      if (!enable) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (rise) begin
              width_q <= WW'(1);
              state_q <= (MIN_WIDTH == 1) ? StHigh : StQualify;
            end
          end
          StQualify: begin
            if (!s) begin
              state_q <= StIdle;
            end else begin
              width_q <= width_q + 1'b1;
              if (inc_acc) state_q <= StHigh;
            end
          end
          StHigh: begin
            if (!s) begin
              if (DEAD_TIME == 0) begin
                state_q <= StIdle;
              end else begin
                dead_q  <= DW'(DEAD_TIME);
                state_q <= StDead;
              end
            end
          end
          StDead: begin
            // Rising edges here are only counted; they never reload dead_q.
            dead_q <= dead_q - 1'b1;
            if (dead_q == DW'(1)) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clock_50_mhz or negedge reset_n) begin
    if (!reset_n) begin
      accepted_count <= '0;
      glitch_count   <= '0;
      deadtime_count <= '0;
      overflow       <= 1'b0;
    end else if (clear_stats) begin
      accepted_count <= '0;
      glitch_count   <= '0;
      deadtime_count <= '0;
      overflow       <= 1'b0;
    end else begin
      if (inc_acc) begin
        if (&accepted_count) overflow <= 1'b1;
        else                 accepted_count <= accepted_count + 1'b1;
      end
      if (inc_glitch) begin
        if (&glitch_count) overflow <= 1'b1;
        else               glitch_count <= glitch_count + 1'b1;
      end
      if (inc_dead) begin
        if (&deadtime_count) overflow <= 1'b1;
        else                 deadtime_count <= deadtime_count + 1'b1;
      end
    end
  end

endmodule
